// File: rtl/flex_down_counter.sv
// Loadable down-counter / terminal-count timer with IDLE/RUN control.
// Define FLEX_DOWN_COUNTER_AUTO_RELOAD_EN to add the auto_reload input and the reload register.
module flex_down_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    input  logic                    auto_reload,
`endif
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    busy,
    output logic                    last_flag,
    output logic                    done_pulse,
    output logic                    underflow_err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    state_t                  state_q, state_d;
    logic [NUM_CNT_BITS-1:0] count_q, count_d;
    logic                    last_q, last_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;
    logic                    reload_now;

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    logic [NUM_CNT_BITS-1:0] reload_q, reload_d;
`endif

    always_comb begin
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        reload_d   = reload_q;
        reload_now = auto_reload && (reload_q != '0);
`else
        reload_now = 1'b0;
`endif
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        err_d   = err_q;

        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            err_d   = 1'b0;
        end else if (load) begin
            count_d = load_val;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
            reload_d = load_val;
`endif
            // a zero-length run completes immediately
            if (load_val != '0) begin
                state_d = RUN;
            end else begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
        end else if (count_enable) begin
            if (state_q == RUN) begin
                if (count_q == ONE) begin
                    done_d = 1'b1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
                    if (reload_now) begin
                        count_d = reload_q;
                    end else begin
                        count_d = '0;
                        state_d = IDLE;
                    end
`else
                    count_d = '0;
                    state_d = IDLE;
`endif
                end else if (count_q != '0) begin
                    count_d = count_q - ONE;
                end
            end else if (count_q == '0) begin
                err_d = 1'b1;
            end
        end

        last_d = (state_d == RUN) && (count_d == ONE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            count_q <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            reload_q <= '0;
        end else begin
            reload_q <= reload_d;
        end
    end
`else
    logic unused_reload;
    assign unused_reload = reload_now;
`endif

    assign count_out     = count_q;
    assign busy          = (state_q == RUN);
    assign last_flag     = last_q;
    assign done_pulse    = done_q;
    assign underflow_err = err_q;

endmodule

// File: tb/tb_flex_down_counter.sv
// Self-checking bench for flex_down_counter: vector table, corner sequences, randomized run vs model.
// Exercises the auto-reload sequences when FLEX_DOWN_COUNTER_AUTO_RELOAD_EN is defined.
module tb_flex_down_counter;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         n_rst;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic         count_enable;
    logic         auto_reload;
    logic [W-1:0] count_out;
    logic         busy;
    logic         last_flag;
    logic         done_pulse;
    logic         underflow_err;

    int total = 0;
    int bad   = 0;

    // behavioural reference state
    int m_cnt;
    bit m_busy;
    bit m_done;
    bit m_err;
    int m_reload;

    always #5 clk = ~clk;

    flex_down_counter #(.NUM_CNT_BITS(W)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .load         (load),
        .load_val     (load_val),
        .count_enable (count_enable),
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        .auto_reload  (auto_reload),
`endif
        .count_out    (count_out),
        .busy         (busy),
        .last_flag    (last_flag),
        .done_pulse   (done_pulse),
        .underflow_err(underflow_err)
    );

    typedef struct {
        bit       clr;
        bit       ld;
        bit [3:0] lv;
        bit       en;
        int       cnt;
        bit       bsy;
        bit       lst;
        bit       dn;
        bit       er;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input int cnt, input bit bsy, input bit lst,
                           input bit dn, input bit er);
        chk({tag, ".count"}, int'(count_out), cnt);
        chk({tag, ".busy"}, int'(busy), int'(bsy));
        chk({tag, ".last"}, int'(last_flag), int'(lst));
        chk({tag, ".done"}, int'(done_pulse), int'(dn));
        chk({tag, ".err"}, int'(underflow_err), int'(er));
    endtask

    task automatic chk_model(input string tag);
        chk_all(tag, m_cnt, m_busy, m_busy && (m_cnt == 1), m_done, m_err);
    endtask

    task automatic model_reset();
        m_cnt = 0; m_busy = 0; m_done = 0; m_err = 0; m_reload = 0;
    endtask

    // one clock of the specified behaviour, expressed on integer counts
    task automatic model_step(input bit c, input bit l, input int lv, input bit e, input bit ar);
        m_done = 0;
        if (c) begin
            m_cnt = 0; m_busy = 0; m_err = 0;
        end else if (l) begin
            m_cnt = lv; m_reload = lv; m_busy = (lv > 0); m_done = (lv == 0);
        end else if (e) begin
            if (m_busy) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_done = 1;
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
                    if (ar && m_reload > 0) m_cnt = m_reload;
                    else m_busy = 0;
`else
                    m_busy = 0;
`endif
                end
            end else if (m_cnt == 0) begin
                m_err = 1;
            end
        end
    endtask

    task automatic drive(input bit c, input bit l, input int lv, input bit e);
        clear = c; load = l; load_val = W'(lv); count_enable = e;
        model_step(c, l, lv, e, auto_reload);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[17];

    initial begin
        n_rst = 1'b0; clear = 0; load = 0; load_val = '0; count_enable = 0; auto_reload = 0;
        model_reset();
        #2;
        chk_all("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 n_rst = 1'b1;

        tbl[0]  = '{0,1,3,0, 3,1,0,0,0};
        tbl[1]  = '{0,0,0,1, 2,1,0,0,0};
        tbl[2]  = '{0,0,0,1, 1,1,1,0,0};
        tbl[3]  = '{0,0,0,1, 0,0,0,1,0};
        tbl[4]  = '{0,0,0,0, 0,0,0,0,0};
        tbl[5]  = '{0,1,5,0, 5,1,0,0,0};
        tbl[6]  = '{0,0,0,1, 4,1,0,0,0};
        tbl[7]  = '{0,0,0,1, 3,1,0,0,0};
        tbl[8]  = '{0,1,2,1, 2,1,0,0,0};
        tbl[9]  = '{0,0,0,1, 1,1,1,0,0};
        tbl[10] = '{0,0,0,0, 1,1,1,0,0};
        tbl[11] = '{0,0,0,1, 0,0,0,1,0};
        tbl[12] = '{0,1,0,0, 0,0,0,1,0};
        tbl[13] = '{0,0,0,0, 0,0,0,0,0};
        tbl[14] = '{0,0,0,1, 0,0,0,0,1};
        tbl[15] = '{0,1,4,0, 4,1,0,0,1};
        tbl[16] = '{1,0,0,0, 0,0,0,0,0};
        for (int i = 0; i < 17; i++) begin
            drive(tbl[i].clr, tbl[i].ld, int'(tbl[i].lv), tbl[i].en);
            chk_all($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].bsy, tbl[i].lst, tbl[i].dn, tbl[i].er);
        end

        // asynchronous reset mid-run must act without a clock edge
        drive(0, 1, 7, 0);
        chk_all("load7", 7, 1, 0, 0, 0);
        #3 n_rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1 n_rst = 1'b1;
        drive(0, 0, 0, 0);
        chk_all("after_rst", 0, 0, 0, 0, 0);

        // load 15 with enable on every other cycle: 15 enables over 29 clocks
        drive(0, 1, 15, 0);
        for (int k = 0; k < 29; k++) begin
            drive(0, 0, 0, (k % 2) == 0);
            chk("gated.count", int'(count_out), 15 - (k + 2) / 2);
            chk("gated.done", int'(done_pulse), (k == 28) ? 1 : 0);
        end
        chk("gated.busy", int'(busy), 0);

        // repeat run aborted by clear at count 4
        drive(0, 1, 15, 0);
        for (int k = 0; k < 11; k++) drive(0, 0, 0, 1);
        chk_all("pre_clear", 4, 1, 0, 0, 0);
        drive(1, 0, 0, 1);
        chk_all("clear", 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk_all("post_clear", 0, 0, 0, 0, 0);

`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
        auto_reload = 1'b1;
        drive(0, 1, 2, 0);
        chk_all("ar_load", 2, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 0, 0, 1);
            chk_all("ar_run", (k % 2 == 0) ? 1 : 2, 1, (k % 2) == 0, (k % 2) == 1, 0);
        end
        auto_reload = 1'b0;
        drive(0, 0, 0, 1);
        chk_all("ar_last", 1, 1, 1, 0, 0);
        drive(0, 0, 0, 1);
        chk_all("ar_end", 0, 0, 0, 1, 0);
`endif

        // randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
`ifdef FLEX_DOWN_COUNTER_AUTO_RELOAD_EN
            auto_reload = ($urandom_range(0, 3) != 0);
`endif
            drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 9) == 0),
                  int'($urandom_range(0, 15)), ($urandom_range(0, 2) != 0));
            chk_model("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flex_down_counter.md
Name: flex_down_counter

Overview:
- Loadable, parameterised down-counter and terminal-count timer.
- Complements the up-counting rollover counter used throughout the packet processor.
- A transmit-side unit loads a byte or bit count and decrements it once per consumed unit. The block reports when the count reaches the last unit and when it reaches zero.
- Used for TX length tracking, bit-stuff windows and timeout countdowns.

Parameters:
- NUM_CNT_BITS, 4, width of the counter and of the load value.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- clear  input  1  synchronous abort; return to IDLE with count 0.
- load  input  1  synchronous load of load_val; starts a run.
- load_val  input  NUM_CNT_BITS  start count (unsigned).
- count_enable  input  1  decrement strobe, one unit per cycle high.
- count_out  output  NUM_CNT_BITS  current count, registered.
- busy  output  1  high while in RUN, registered.
- last_flag  output  1  high when busy and count_out == 1, registered.
- done_pulse  output  1  one-cycle pulse when a run reaches 0, registered.
- underflow_err  output  1  sticky error: decrement requested while count_out == 0.

Behaviour:
- Reset (n_rst low, asynchronous): state IDLE, count_out = 0, busy = 0, last_flag = 0, done_pulse = 0, underflow_err = 0.
- FSM states:
  - IDLE: no run active.
  - RUN: counting down.
  - busy = (state == RUN).
- Priority each cycle: clear > load > count_enable.
- clear = 1:
  - next state IDLE, count_out <= 0.
  - underflow_err <= 0, done_pulse <= 0.
  - No done pulse for an aborted run.
- load = 1 (clear = 0):
  - count_out <= load_val.
  - load_val != 0: next state RUN.
  - load_val == 0: next state IDLE and done_pulse <= 1 on the next cycle (zero-length run completes immediately).
  - Legal in any state. A load during RUN restarts the run without a done pulse.
  - A simultaneous count_enable is ignored (no decrement that cycle).
- RUN, count_enable = 1:
  - count_out <= count_out - 1.
  - If count_out == 1: count_out <= 0, next state IDLE, done_pulse <= 1. The pulse is high in the same cycle count_out first reads 0.
- RUN, count_enable = 0: hold all state.
- IDLE, count_enable = 1, count_out == 0:
  - count_out stays 0; no wrap to all-ones.
  - underflow_err <= 1 and holds until clear or reset. A load does not clear it.
- done_pulse is high for exactly one cycle per completed run, otherwise 0.
- last_flag is registered from the next-state values: high in cycles where next busy = 1 and next count_out == 1.
- Latency: a load or decrement is visible on count_out one cycle after the sampling edge.
- Max load_val = 2^NUM_CNT_BITS - 1; arithmetic is unsigned and never wraps.

Optional Feature:
- Macro: FLEX_DOWN_COUNTER_AUTO_RELOAD_EN.
- With the macro defined:
  - Adds input port auto_reload (1 bit) and an internal reload register (NUM_CNT_BITS bits, reset 0) captured on every load.
  - When RUN decrements from 1 with auto_reload = 1: done_pulse <= 1, count_out <= reload register, state stays RUN.
  - If the reload register is 0, the block behaves as if auto_reload were 0.
  - clear still has priority and returns to IDLE.
- Without the macro: no auto_reload port and no reload register; every run ends in IDLE.

Test Plan (NUM_CNT_BITS = 4):
- Reset with n_rst low mid-run (count 7) -> all outputs 0 immediately, without waiting for a clock edge; state IDLE.
- load = 1 with load_val = 3, then count_enable held high -> count_out sequence 3, 2, 1, 0. last_flag high while count = 1. done_pulse high only in the cycle count = 0. busy falls in the same cycle.
- load_val = 5, enable for 2 cycles, then load_val = 2 with load and enable both high -> count_out = 2, no done_pulse, busy stays 1.
- load_val = 0 -> count_out = 0 and done_pulse = 1 for one cycle; busy never rises. A following count_enable -> underflow_err = 1 and count_out stays 0. Then clear -> underflow_err = 0.
- load_val = 15 with enable gated every other cycle -> reaches 0 after 15 enable cycles (29 clocks). clear asserted at count = 4 in a repeat run -> IDLE, count 0, no done_pulse.
- FLEX_DOWN_COUNTER_AUTO_RELOAD_EN defined, auto_reload = 1, load_val = 2, enable held -> count 2, 1, 2, 1, ... with done_pulse on each reload cycle. Dropping auto_reload -> final run ends at 0 in IDLE.
